// File: rtl/issue_queue_if.sv
// Decoder/launch-side handshake bundle for the dual-issue instruction queue.
interface issue_queue_if #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 32,
    parameter int DC_W  = 67
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            flush;
    logic            in1_valid;
    logic [PC_W-1:0] in1_pc;
    logic [PC_W-1:0] in1_npc;
    logic [DC_W-1:0] in1_decodeout;
    logic            in2_valid;
    logic [PC_W-1:0] in2_pc;
    logic [PC_W-1:0] in2_npc;
    logic [DC_W-1:0] in2_decodeout;
    logic            in_ready;
    logic            out1_valid;
    logic [PC_W-1:0] out1_pc;
    logic [PC_W-1:0] out1_npc;
    logic [DC_W-1:0] out1_decodeout;
    logic            out2_valid;
    logic [PC_W-1:0] out2_pc;
    logic [PC_W-1:0] out2_npc;
    logic [DC_W-1:0] out2_decodeout;
    logic [3:0]      launch_flag;
    logic [CW-1:0]   count;

    modport master (
        output flush, in1_valid, in1_pc, in1_npc, in1_decodeout,
               in2_valid, in2_pc, in2_npc, in2_decodeout, launch_flag,
        input  in_ready, out1_valid, out1_pc, out1_npc, out1_decodeout,
               out2_valid, out2_pc, out2_npc, out2_decodeout, count
    );

    modport slave (
        input  flush, in1_valid, in1_pc, in1_npc, in1_decodeout,
               in2_valid, in2_pc, in2_npc, in2_decodeout, launch_flag,
        output in_ready, out1_valid, out1_pc, out1_npc, out1_decodeout,
               out2_valid, out2_pc, out2_npc, out2_decodeout, count
    );
endinterface

// File: rtl/issue_queue.sv
// Dual-issue in-order instruction queue: 2-wide push from decode, 0/1/2 retire per cycle.
// Define ISSUE_QUEUE_BYPASS_EN to let an empty queue forward decoder inputs straight to launch.
module issue_queue #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 32,
    parameter int DC_W  = 67
) (
    input logic        clk,
    input logic        rst,
    issue_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 * PC_W + DC_W;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count;

    logic          in_ready;
    logic [EW-1:0] ent1, ent2, cmp0, cmp1;
    logic [EW-1:0] rd1, rd2, wr0, wr1;
    logic [1:0]    n_push, n_pop, n_wr, head_adv;
    logic          v1, v2, pop1, pop2, byp, accept;

    always_comb begin
        in_ready = (count <= CW'(DEPTH - 2));
        ent1     = {q.in1_pc, q.in1_npc, q.in1_decodeout};
        ent2     = {q.in2_pc, q.in2_npc, q.in2_decodeout};
        // Compaction: a lone in2 is treated as the first instruction of the pair.
        cmp0     = q.in1_valid ? ent1 : ent2;
        cmp1     = ent2;
        n_push   = {1'b0, q.in1_valid} + {1'b0, q.in2_valid};

        rd1 = mem[head];
        rd2 = mem[head + AW'(1)];
        v1  = (count != '0);
        v2  = (count >= CW'(2));
        byp = 1'b0;
`ifdef ISSUE_QUEUE_BYPASS_EN
        if (count == '0 && !q.flush) begin
            byp = 1'b1;
            v1  = (n_push != 2'd0);
            v2  = (n_push == 2'd2);
            rd1 = cmp0;
            rd2 = cmp1;
        end
`endif

        // Slot 2 may only retire together with slot 1 to keep issue in order.
        pop1  = v1 & (q.launch_flag[3] | q.launch_flag[2]);
        pop2  = pop1 & v2 & (q.launch_flag[1] | q.launch_flag[0]);
        n_pop = {1'b0, pop1} + {1'b0, pop2};

        accept   = in_ready & ~q.flush;
        n_wr     = 2'd0;
        wr0      = cmp0;
        wr1      = cmp1;
        head_adv = n_pop;
        if (byp) begin
            // Bypassed instructions already launched are never stored.
            head_adv = 2'd0;
            n_wr     = n_push - n_pop;
            wr0      = (n_pop == 2'd0) ? cmp0 : cmp1;
        end else if (accept) begin
            n_wr = n_push;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (q.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(head_adv);
            tail  <= tail + AW'(n_wr);
            count <= count + CW'(n_wr) - CW'(head_adv);
        end
    end

    // Entry storage carries no reset; valid flags derive solely from count.
    always_ff @(posedge clk) begin
        if (n_wr != 2'd0) mem[tail] <= wr0;
        if (n_wr == 2'd2) mem[tail + AW'(1)] <= wr1;
    end

    assign q.in_ready       = in_ready;
    assign q.count          = count;
    assign q.out1_valid     = v1;
    assign q.out2_valid     = v2;
    assign q.out1_pc        = rd1[EW-1 -: PC_W];
    assign q.out1_npc       = rd1[DC_W +: PC_W];
    assign q.out1_decodeout = rd1[DC_W-1:0];
    assign q.out2_pc        = rd2[EW-1 -: PC_W];
    assign q.out2_npc       = rd2[DC_W +: PC_W];
    assign q.out2_decodeout = rd2[DC_W-1:0];
endmodule
